// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED fill/drain sequencer.
// Build option: LED_BOUNCE_EN alternates the fill/drain bit order per pass.
package led_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    HOLD_FULL,
    DRAIN,
    HOLD_EMPTY
  } state_t;

  localparam logic [7:0] LED_ALL_ON  = 8'hFF;
  localparam logic [7:0] LED_ALL_OFF = 8'h00;
  localparam int         SPEED_W     = 2;

  // msb=1 shifts toward bit 0 and inserts at bit 7
  function automatic logic [7:0] led_shift(
    input logic [7:0] cur,
    input logic       fill,
    input logic       msb
  );
    if (msb) return {fill, cur[7:1]};
    return {cur[6:0], fill};
  endfunction

endpackage

// File: rtl/step_tick_gen.sv
// Step-rate divider producing a registered single-cycle step enable.
// The count freezes while sw_run is low, so no partial period is lost.
module step_tick_gen
  import led_seq_pkg::*;
#(
  parameter int BASE_DIV = 50_000_000
) (
  input  logic               clk50m,
  input  logic               rst,
  input  logic               sw_run,
  input  logic [SPEED_W-1:0] speed_sel,
  output logic               step_tick
);

  localparam int CW = $clog2(BASE_DIV);

  logic [CW-1:0] cnt;
  logic [31:0]   term_m1;
  logic          at_term;

  assign term_m1 = (32'(BASE_DIV) >> speed_sel) - 32'd1;
  // >= so a shorter period selected mid-count fires at once
  assign at_term = (32'(cnt) >= term_m1);

  always_ff @(posedge clk50m) begin
    if (rst) begin
      cnt       <= '0;
      step_tick <= 1'b0;
    end else if (!sw_run) begin
      step_tick <= 1'b0;
    end else if (at_term) begin
      cnt       <= '0;
      step_tick <= 1'b1;
    end else begin
      cnt       <= cnt + CW'(1);
      step_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/led_fill_drain_ctrl.sv
// 8-LED bar sequencer: fill, hold, drain, hold, repeat on each step tick.
// Build option: LED_BOUNCE_EN flips the bit order after every HOLD_EMPTY.
module led_fill_drain_ctrl
  import led_seq_pkg::*;
#(
  parameter int BASE_DIV = 50_000_000
) (
  input  logic               clk50m,
  input  logic               rst,
  input  logic               sw_run,
  input  logic [SPEED_W-1:0] speed_sel,
  output logic [7:0]         led,
  output logic               step_tick
);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] led_d;
  logic       dir_q;

  step_tick_gen #(
    .BASE_DIV (BASE_DIV)
  ) u_tick (
    .clk50m    (clk50m),
    .rst       (rst),
    .sw_run    (sw_run),
    .speed_sel (speed_sel),
    .step_tick (step_tick)
  );

`ifdef LED_BOUNCE_EN
  logic dir_d;

  always_comb begin
    dir_d = dir_q;
    if (step_tick && state_q == HOLD_EMPTY) dir_d = ~dir_q;
  end

  always_ff @(posedge clk50m) begin
    if (rst) dir_q <= 1'b0;
    else     dir_q <= dir_d;
  end
`else
  assign dir_q = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    led_d   = led;
    unique case (state_q)
      IDLE: begin
        led_d = LED_ALL_OFF;
        if (sw_run) state_d = FILL;
      end
      FILL: begin
        if (step_tick) begin
          led_d = led_shift(led, 1'b1, dir_q);
          if (led_d == LED_ALL_ON) state_d = HOLD_FULL;
        end
      end
      HOLD_FULL: begin
        if (step_tick) state_d = DRAIN;
      end
      DRAIN: begin
        if (step_tick) begin
          led_d = led_shift(led, 1'b0, dir_q);
          if (led_d == LED_ALL_OFF) state_d = HOLD_EMPTY;
        end
      end
      HOLD_EMPTY: begin
        if (step_tick) state_d = FILL;
      end
      default: begin
        state_d = IDLE;
        led_d   = LED_ALL_OFF;
      end
    endcase
  end

  always_ff @(posedge clk50m) begin
    if (rst) begin
      state_q <= IDLE;
      led     <= LED_ALL_OFF;
    end else begin
      state_q <= state_d;
      led     <= led_d;
    end
  end

endmodule

// File: tb/tb_led_fill_drain_ctrl.sv
// Bench for led_fill_drain_ctrl with BASE_DIV=16.
// Build option: LED_BOUNCE_EN selects the ping-pong expectations.
module tb_led_fill_drain_ctrl;

  localparam int BASE_DIV = 16;

  logic       clk50m = 1'b0;
  logic       rst = 1'b1;
  logic       sw_run = 1'b1;
  logic [1:0] speed_sel = 2'd0;
  logic [7:0] led;
  logic       step_tick;

  int tests = 0;
  int fails = 0;

  led_fill_drain_ctrl #(
    .BASE_DIV (BASE_DIV)
  ) dut (
    .clk50m    (clk50m),
    .rst       (rst),
    .sw_run    (sw_run),
    .speed_sel (speed_sel),
    .led       (led),
    .step_tick (step_tick)
  );

  always #5 clk50m = ~clk50m;

  // Reference: ticks consumed since leaving idle, mapped to a pattern.
  int m_cnt  = 0;
  bit m_tick = 1'b0;
  bit m_idle = 1'b1;
  int m_n    = 0;

  function automatic void model_edge();
    if (rst) begin
      m_cnt  = 0;
      m_tick = 1'b0;
      m_idle = 1'b1;
      m_n    = 0;
      return;
    end
    if (m_idle) begin
      if (sw_run) m_idle = 1'b0;
    end else if (m_tick) begin
      m_n++;
    end
    if (!sw_run) begin
      m_tick = 1'b0;
    end else if (m_cnt >= (BASE_DIV >> speed_sel) - 1) begin
      m_cnt  = 0;
      m_tick = 1'b1;
    end else begin
      m_cnt++;
      m_tick = 1'b0;
    end
  endfunction

  function automatic logic [7:0] model_led();
    int         p;
    int         ones;
    bit         msb;
    bit         low;
    logic [7:0] ff;
    logic [7:0] lowm;
    logic [7:0] highm;
    if (m_idle) return 8'h00;
    ff  = 8'hFF;
    p   = m_n % 18;
    msb = 1'b0;
`ifdef LED_BOUNCE_EN
    msb = ((m_n / 18) % 2) == 1;
`endif
    if (p == 0)      ones = 0;
    else if (p <= 8) ones = p;
    else if (p == 9) ones = 8;
    else             ones = 17 - p;
    lowm  = ~(ff << ones);
    highm = ~(ff >> ones);
    low   = (p <= 9) ^ msb;
    return low ? lowm : highm;
  endfunction

  function automatic void check(
    input string      name,
    input logic [7:0] act,
    input logic [7:0] exp
  );
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %02h, want %02h at %0t",
               name, act, exp, $time);
    end
  endfunction

  task automatic step();
    @(posedge clk50m);
    model_edge();
    #1;
  endtask

  typedef struct {
    logic       rst;
    logic       run;
    logic [1:0] spd;
    int         cyc;
    logic [7:0] led;
    logic       tick;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] nxt[18];

  initial begin
    int   ticks;
    bit   bad;
    logic [7:0] prev;

    nxt = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
            8'hFF, 8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0,
            8'hE0, 8'hC0, 8'h80, 8'h00, 8'h00, 8'h01};
`ifdef LED_BOUNCE_EN
    nxt[17] = 8'h80;
`endif
    for (int i = 0; i < 3; i++)
      tbl.push_back('{1'b1, 1'b1, 2'd0, 1, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 2'd0, 15, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 2'd0, 1, 8'h00, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 2'd0, 1, 8'h01, 1'b0});
    prev = 8'h01;
    for (int i = 0; i < 18; i++) begin
      tbl.push_back('{1'b0, 1'b1, 2'd0, 15, prev, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 2'd0, 1, nxt[i], 1'b0});
      prev = nxt[i];
    end

    foreach (tbl[i]) begin
      rst       = tbl[i].rst;
      sw_run    = tbl[i].run;
      speed_sel = tbl[i].spd;
      repeat (tbl[i].cyc) step();
      check($sformatf("vec%0d_led", i), led, tbl[i].led);
      check($sformatf("vec%0d_tick", i),
            {7'd0, step_tick}, {7'd0, tbl[i].tick});
    end

    // Speed change mid-count
    rst = 1'b1; step();
    rst = 1'b0; sw_run = 1'b1; speed_sel = 2'd0;
    repeat (10) step();
    speed_sel = 2'd3;
    step(); check("spd_fast0", {7'd0, step_tick}, 8'd1);
    step(); check("spd_fast1", {7'd0, step_tick}, 8'd0);
    step(); check("spd_fast2", {7'd0, step_tick}, 8'd1);
    step(); check("spd_fast3", {7'd0, step_tick}, 8'd0);
    step(); check("spd_fast4", {7'd0, step_tick}, 8'd1);
    speed_sel = 2'd0;
    ticks = 0;
    repeat (15) begin step(); ticks += int'(step_tick); end
    check("spd_slow_gap", 8'(ticks), 8'd0);
    step(); check("spd_slow_tick", {7'd0, step_tick}, 8'd1);

    // Freeze at 07 and resume
    rst = 1'b1; step();
    rst = 1'b0;
    for (int k = 0; k < 200 && led !== 8'h07; k++) step();
    check("reach07", led, 8'h07);
    sw_run = 1'b0;
    bad = 1'b0;
    repeat (100) begin
      step();
      if (led !== 8'h07 || step_tick !== 1'b0) bad = 1'b1;
    end
    check("freeze", {7'd0, bad}, 8'd0);
    sw_run = 1'b1;
    ticks = 0;
    repeat (14) begin step(); ticks += int'(step_tick); end
    check("resume_gap", 8'(ticks), 8'd0);
    step();
    check("resume_tick", {7'd0, step_tick}, 8'd1);
    check("resume_hold", led, 8'h07);
    step();
    check("resume_0f", led, 8'h0F);

    // Reset mid-drain
    for (int k = 0; k < 400 && led !== 8'hF0; k++) step();
    check("reachF0", led, 8'hF0);
    rst = 1'b1; step();
    check("rst_led", led, 8'h00);
    check("rst_tick", {7'd0, step_tick}, 8'd0);
    rst = 1'b0;
    repeat (16) step();
    check("refill_tick", {7'd0, step_tick}, 8'd1);
    check("refill_pre", led, 8'h00);
    step();
    check("refill_01", led, 8'h01);

    // Randomised run against the reference
    rst = 1'b1; step();
    rst = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 29) == 0) sw_run = ~sw_run;
      if ($urandom_range(0, 49) == 0)
        speed_sel = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 399) == 0);
      step();
      check("rnd_led", led, model_led());
      check("rnd_tick", {7'd0, step_tick}, {7'd0, m_tick});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
